// File: rtl/regfile_bist_if.sv
// Write/read bus between regfile_bist (master) and the 2R1W regfile (slave).
// Master drives the write port and both read addresses; the slave returns both read data words.
interface regfile_bist_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr_0;
   logic [ADDR_W-1:0] rd_addr_1;
   logic [DATA_W-1:0] rd_data_0;
   logic [DATA_W-1:0] rd_data_1;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr_0, rd_addr_1,
      input  rd_data_0, rd_data_1
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr_0, rd_addr_1,
      output rd_data_0, rd_data_1
   );
endinterface

// File: rtl/regfile_bist.sv
// Regfile BIST: writes addr*PATTERN_MULT to every entry, reads all back on both ports, reports pass/fail.
// Latency: done at 129+RD_LAT cycles after start (two passes with REGFILE_BIST_INV_PASS_EN: 2*(128+RD_LAT)+1).
// Backpressure: none; start is ignored while busy. REGFILE_BIST_INV_PASS_EN adds an inverted-data pass.
module regfile_bist #(
   parameter int                ADDR_W       = 6,
   parameter int                DATA_W       = 16,
   parameter logic [DATA_W-1:0] PATTERN_MULT = 16'h2408,
   parameter int                RD_LAT       = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        fail_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic              fail_port,
   regfile_bist_if.master    rf
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              inv_q, inv_d;
   logic              accept;

   logic              wr_en_d, issue_d, busy_d, done_d;
   logic [ADDR_W-1:0] wr_addr_d, rd_addr_0_d, rd_addr_1_d;
   logic [DATA_W-1:0] wr_data_d;

   logic [RD_LAT:0]   pipe_vld;
   logic [RD_LAT:0]   pipe_inv;
   logic [ADDR_W-1:0] pipe_addr [RD_LAT+1];

   logic              cmp_vld, mis0, mis1;
   logic [ADDR_W-1:0] cmp_addr_0, cmp_addr_1;
   logic [8:0]        fail_sum;
   logic [7:0]        fail_cnt_d;
   logic [ADDR_W-1:0] fail_addr_d;
   logic              fail_port_d;

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
      logic [DATA_W-1:0] p;
      p = DATA_W'(a) * PATTERN_MULT;
      return inv ? ~p : p;
   endfunction

   assign accept = start && (state_q == IDLE || state_q == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef REGFILE_BIST_INV_PASS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inv_q <= 1'b0;
      else        inv_q <= inv_d;
   end
`else
   assign inv_q = 1'b0;
`endif

   // Counters wrap naturally, so each phase is entered with cnt already at 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef REGFILE_BIST_INV_PASS_EN
      inv_d   = inv_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = WRITE;
               cnt_d   = '0;
`ifdef REGFILE_BIST_INV_PASS_EN
               inv_d   = 1'b0;
`endif
            end
         end
         WRITE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) state_d = READ;
         end
         READ: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) state_d = DRAIN;
         end
         DRAIN: begin
            cnt_d = cnt_q + 1'b1;
`ifdef REGFILE_BIST_INV_PASS_EN
            // Second pass overlaps the last compare of the first; pipe_inv keeps them apart.
            if (!inv_q && cnt_q == ADDR_W'(RD_LAT - 1)) begin
               state_d = WRITE;
               cnt_d   = '0;
               inv_d   = 1'b1;
            end else
`endif
            if (cnt_q == ADDR_W'(RD_LAT)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifndef REGFILE_BIST_INV_PASS_EN
   assign inv_d = 1'b0;
`endif

   always_comb begin
      wr_en_d     = (state_d == WRITE);
      wr_addr_d   = wr_en_d ? cnt_d : '0;
      wr_data_d   = wr_en_d ? pattern(cnt_d, inv_d) : '0;
      issue_d     = (state_d == READ);
      rd_addr_1_d = issue_d ? cnt_d : '0;
      rd_addr_0_d = issue_d ? cnt_d - 1'b1 : '0;
      busy_d      = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
      done_d      = (state_d == DONE);
   end

   assign cmp_vld    = pipe_vld[RD_LAT];
   assign cmp_addr_1 = pipe_addr[RD_LAT];
   assign cmp_addr_0 = cmp_addr_1 - 1'b1;
   assign mis0       = cmp_vld && (rf.rd_data_0 != pattern(cmp_addr_0, pipe_inv[RD_LAT]));
   assign mis1       = cmp_vld && (rf.rd_data_1 != pattern(cmp_addr_1, pipe_inv[RD_LAT]));
   assign fail_sum   = {1'b0, fail_count} + {8'd0, mis0} + {8'd0, mis1};

   always_comb begin
      fail_cnt_d  = fail_count;
      fail_addr_d = fail_addr;
      fail_port_d = fail_port;
      if (accept) begin
         fail_cnt_d  = '0;
         fail_addr_d = '0;
         fail_port_d = 1'b0;
      end else begin
         // fail_count never returns to zero once set, so zero means no failure captured yet.
         if (fail_count == 8'd0) begin
            if (mis0) begin
               fail_addr_d = cmp_addr_0;
               fail_port_d = 1'b0;
            end else if (mis1) begin
               fail_addr_d = cmp_addr_1;
               fail_port_d = 1'b1;
            end
         end
         fail_cnt_d = fail_sum[8] ? 8'hFF : fail_sum[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf.wr_en     <= 1'b0;
         rf.wr_addr   <= '0;
         rf.wr_data   <= '0;
         rf.rd_addr_0 <= '0;
         rf.rd_addr_1 <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         fail_count   <= '0;
         fail_addr    <= '0;
         fail_port    <= 1'b0;
         pipe_vld     <= '0;
         pipe_inv     <= '0;
         for (int i = 0; i <= RD_LAT; i++) pipe_addr[i] <= '0;
      end else begin
         rf.wr_en     <= wr_en_d;
         rf.wr_addr   <= wr_addr_d;
         rf.wr_data   <= wr_data_d;
         rf.rd_addr_0 <= rd_addr_0_d;
         rf.rd_addr_1 <= rd_addr_1_d;
         busy         <= busy_d;
         done         <= done_d;
         pass         <= done_d && (fail_cnt_d == 8'd0);
         fail_count   <= fail_cnt_d;
         fail_addr    <= fail_addr_d;
         fail_port    <= fail_port_d;
         pipe_vld     <= {pipe_vld[RD_LAT-1:0], issue_d};
         pipe_inv     <= {pipe_inv[RD_LAT-1:0], inv_d};
         pipe_addr[0] <= cnt_d;
         for (int i = 1; i <= RD_LAT; i++) pipe_addr[i] <= pipe_addr[i-1];
      end
   end

endmodule
